iod_dly_line_ctrl: RTL and testbench
====================================

IOD_DLY_LINE_CTRL -- requirements
Module: iod_dly_line_ctrl

Interface
REQ-001 Parameter: NUM_LANES, 4, number of IOD delay lines sequenced (2..8).
REQ-002 Parameter: TAP_W, 8, width of tap count and tap position.
REQ-003 Parameter: SETTLE_CYC, 4, FAB_CLK cycles waited after each MOVE or LOAD pulse (>=1).
REQ-004 Port: FAB_CLK  in  1  sole clock; all logic rising-edge.
REQ-005 Port: ARST_N  in  1  asynchronous active-low reset.
REQ-006 Port: REQ_VALID  in  1  request present.
REQ-007 Port: REQ_READY  out  1  controller accepts a request this cycle.
REQ-008 Port: REQ_LANE  in  3  target lane index.
REQ-009 Port: REQ_OP  in  2  00 step up, 01 step down, 10 load, 11 reserved.
REQ-010 Port: REQ_COUNT  in  TAP_W  taps to step (ignored for load).
REQ-011 Port: DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse.
REQ-012 Port: DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1 = up.
REQ-013 Port: DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse.
REQ-014 Port: DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane limit flag, FAB_CLK domain.
REQ-015 Port: DONE  out  1  one-cycle completion pulse.
REQ-016 Port: ERR  out  1  qualified by DONE; request failed or stopped at limit.
REQ-017 Port: DONE_TAPS  out  TAP_W  taps actually moved, valid with DONE.
REQ-018 Port: RD_LANE  in  3  readback lane select.
REQ-019 Port: RD_POS  out  TAP_W  tracked tap position of RD_LANE, combinational read; 0 if RD_LANE >= NUM_LANES.

Function
REQ-020 FSM states: IDLE, SETUP, PULSE, SETTLE, LOADP, FIN; all outputs except RD_POS registered.
REQ-021 REQ_READY = 1 only in IDLE; handshake = REQ_VALID & REQ_READY; inputs captured at handshake; REQ_* ignored otherwise.
REQ-022 REQ_LANE >= NUM_LANES or REQ_OP = 11: IDLE -> FIN, DONE=1, ERR=1, DONE_TAPS=0, no pulse issued.
REQ-023 Step with REQ_COUNT = 0: IDLE -> FIN, DONE=1, ERR=0, DONE_TAPS=0, no pulse.
REQ-024 Step: SETUP (1 cycle) drives DIRECTION[lane] = (op==00); DIRECTION held until next SETUP for that lane.
REQ-025 PULSE: MOVE[lane]=1 for exactly one cycle; then SETTLE for SETTLE_CYC cycles.
REQ-026 Last SETTLE cycle samples OUT_OF_RANGE[lane]: 1 -> FIN with ERR=1, position unchanged for that step; 0 -> POS[lane] +/-1, moved count +1, then PULSE if remaining > 0 else FIN.
REQ-027 Step latency: handshake at cycle 0, MOVE k at cycle 2+(k-1)*(1+SETTLE_CYC), DONE at cycle 2+N*(1+SETTLE_CYC).
REQ-028 Load: LOADP drives LOAD[lane]=1 one cycle, SETTLE_CYC cycles wait, POS[lane]=0, FIN; DONE_TAPS=0, ERR=0; OUT_OF_RANGE ignored.
REQ-029 POS arithmetic modulo 2^TAP_W (OUT_OF_RANGE guards real limits); no saturation logic.
REQ-030 FIN lasts one cycle (DONE=1), then IDLE; at most one MOVE/LOAD bit high at any time.

Reset
REQ-031 ARST_N low, asynchronously: FSM IDLE, MOVE/LOAD/DIRECTION/DONE/ERR/DONE_TAPS = 0, all POS = 0, REQ_READY = 0 while reset asserted, 1 first cycle after release.
REQ-032 Reset mid-operation aborts the request with no DONE; no pulse emitted after reset release until a new handshake.

Verification
REQ-033 SETTLE_CYC=4, lane 1 up, count 3 -> MOVE[1] at cycles 2,7,12, DIRECTION[1]=1, DONE at 17, ERR=0, DONE_TAPS=3, RD_POS(1)=3.
REQ-034 Lane 2 down, count 5, OUT_OF_RANGE[2] raised before 3rd sample -> 3 MOVE pulses, DONE ERR=1, DONE_TAPS=2, POS[2]=254.
REQ-035 Load lane 0 after POS=7 -> LOAD[0] at cycle 1 only, DONE at cycle 6, RD_POS(0)=0.
REQ-036 REQ_LANE=5 (NUM_LANES=4) and REQ_OP=11 -> DONE at cycle 1, ERR=1, no MOVE/LOAD; count 0 step -> DONE ERR=0.
REQ-037 ARST_N low during 2nd SETTLE of count-4 step -> outputs 0 at once, POS cleared, no DONE; REQ_VALID held high during operation not re-accepted until FIN.

Source files
------------

// File: rtl/iod_dly_line_ctrl.sv
// IOD delay-line sequencer: issues per-lane MOVE/LOAD pulses with settle waits,
// honours the per-lane out-of-range flag and tracks every lane's tap position.
module iod_dly_line_ctrl #(
  parameter int NUM_LANES  = 4,
  parameter int TAP_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [2:0]           REQ_LANE,
  input  logic [1:0]           REQ_OP,
  input  logic [TAP_W-1:0]     REQ_COUNT,
  output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
  output logic                 DONE,
  output logic                 ERR,
  output logic [TAP_W-1:0]     DONE_TAPS,
  input  logic [2:0]           RD_LANE,
  output logic [TAP_W-1:0]     RD_POS
);
  // state  | meaning
  // IDLE   | ready for a request
  // SETUP  | direction driven for the target lane
  // PULSE  | MOVE high for one cycle
  // SETTLE | settle wait; the last cycle samples the lane's out-of-range flag
  // LOADP  | LOAD high for one cycle
  // FIN    | DONE pulse carrying ERR and DONE_TAPS
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_SETTLE, S_LOADP, S_FIN
  } state_t;

  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam int         TMR_W   = $clog2(SETTLE_CYC + 1);

  state_t                         state_q, state_d;
  logic                           ready_q, ready_d;
  logic [NUM_LANES-1:0]           move_q, move_d;
  logic [NUM_LANES-1:0]           load_q, load_d;
  logic [NUM_LANES-1:0]           dir_q, dir_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [TAP_W-1:0]               taps_q, taps_d;
  logic [2:0]                     lane_q, lane_d;
  logic [1:0]                     op_q, op_d;
  logic [TAP_W-1:0]               rem_q, rem_d;
  logic [TAP_W-1:0]               cnt_q, cnt_d;
  logic [TMR_W-1:0]               tmr_q, tmr_d;
  logic [NUM_LANES-1:0][TAP_W-1:0] pos_q, pos_d;

  logic [NUM_LANES-1:0] lane_oh;
  logic [NUM_LANES-1:0] req_oh;
  logic                 req_lane_bad;
  logic                 oor_hit;

  always_comb begin
    lane_oh = '0;
    req_oh  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == 3'(i))   lane_oh[i] = 1'b1;
      if (REQ_LANE == 3'(i)) req_oh[i]  = 1'b1;
    end
  end

  assign req_lane_bad = ({1'b0, REQ_LANE} >= 4'(NUM_LANES));
  assign oor_hit      = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    move_d  = '0;
    load_d  = '0;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    taps_d  = taps_q;
    lane_d  = lane_q;
    op_d    = op_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    pos_d   = pos_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && ready_q) begin
          lane_d = REQ_LANE;
          op_d   = REQ_OP;
          rem_d  = REQ_COUNT;
          cnt_d  = '0;
          if (req_lane_bad || REQ_OP == OP_RSVD) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
            taps_d  = '0;
          end else if (REQ_OP == OP_LOAD) begin
            state_d = S_LOADP;
            load_d  = req_oh;
          end else if (REQ_COUNT == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            taps_d  = '0;
          end else begin
            state_d = S_SETUP;
            dir_d   = (dir_q & ~req_oh) | ((REQ_OP == OP_UP) ? req_oh : '0);
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        move_d  = lane_oh;
      end
      S_PULSE, S_LOADP: begin
        state_d = S_SETTLE;
        tmr_d   = TMR_W'(SETTLE_CYC - 1);
      end
      S_SETTLE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (op_q == OP_LOAD) begin
          for (int i = 0; i < NUM_LANES; i++)
            if (lane_oh[i]) pos_d[i] = '0;
          state_d = S_FIN;
          done_d  = 1'b1;
          taps_d  = '0;
        end else if (oor_hit) begin
          // limit reached: this step is not counted and the position stays put
          state_d = S_FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
          taps_d  = cnt_q;
        end else begin
          for (int i = 0; i < NUM_LANES; i++)
            if (lane_oh[i])
              pos_d[i] = (op_q == OP_UP) ? pos_q[i] + TAP_W'(1) : pos_q[i] - TAP_W'(1);
          cnt_d = cnt_q + TAP_W'(1);
          rem_d = rem_q - TAP_W'(1);
          if (rem_q == TAP_W'(1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            taps_d  = cnt_q + TAP_W'(1);
          end else begin
            state_d = S_PULSE;
            move_d  = lane_oh;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      move_q  <= '0;
      load_q  <= '0;
      dir_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      taps_q  <= '0;
      lane_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      move_q  <= move_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      taps_q  <= taps_d;
      lane_q  <= lane_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    RD_POS = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (RD_LANE == 3'(i)) RD_POS = pos_q[i];
  end

  assign REQ_READY            = ready_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;
  assign DONE_TAPS            = taps_q;

endmodule

// File: tb/tb_iod_dly_line_ctrl.sv
// Randomized bench for iod_dly_line_ctrl: a transaction-level timeline model
// predicts every output per cycle; directed cases pin the model with literals.
module tb_iod_dly_line_ctrl;
  localparam int NL  = 4;
  localparam int TW  = 8;
  localparam int S   = 4;
  localparam int TBL = 16384;

  logic          FAB_CLK, ARST_N, REQ_VALID, REQ_READY;
  logic [2:0]    REQ_LANE, RD_LANE;
  logic [1:0]    REQ_OP;
  logic [TW-1:0] REQ_COUNT, DONE_TAPS, RD_POS;
  logic [NL-1:0] MOVE, DIRN, LOAD, OOR;
  logic          DONE, ERR;

  iod_dly_line_ctrl #(.NUM_LANES(NL), .TAP_W(TW), .SETTLE_CYC(S)) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_LANE(REQ_LANE), .REQ_OP(REQ_OP), .REQ_COUNT(REQ_COUNT),
    .DELAY_LINE_MOVE(MOVE), .DELAY_LINE_DIRECTION(DIRN), .DELAY_LINE_LOAD(LOAD),
    .DELAY_LINE_OUT_OF_RANGE(OOR), .DONE(DONE), .ERR(ERR), .DONE_TAPS(DONE_TAPS),
    .RD_LANE(RD_LANE), .RD_POS(RD_POS));

  initial begin
    FAB_CLK = 1'b0;
    forever #5 FAB_CLK = ~FAB_CLK;
  end

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  // per-cycle expectation timeline written by the model, read by the checker
  logic [NL-1:0] e_move [TBL];
  logic [NL-1:0] e_load [TBL];
  bit            e_done [TBL];
  bit            e_err  [TBL];
  bit            e_busy [TBL];
  logic [TW-1:0] e_taps [TBL];
  bit            dir_ev [TBL];
  logic [NL-1:0] dir_val[TBL];
  bit            pos_ev [TBL];
  int            pos_ln [TBL];
  logic [TW-1:0] pos_val[TBL];
  logic [NL-1:0] oor_tab[TBL];

  logic [TW-1:0] mdl_pos[NL];
  logic [NL-1:0] mdl_dir;
  logic [TW-1:0] cur_pos[NL];
  logic [NL-1:0] cur_dir;
  int            ready_from = 1 << 30;
  int            n_tests = 0, n_fail = 0;
  int            obs_move_q[$], obs_load_q[$], obs_done_q[$], obs_err_q[$], obs_taps_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NL-1:0] lane_bit(input int lane);
    logic [NL-1:0] v;
    v = '0;
    v[lane] = 1'b1;
    return v;
  endfunction

  task automatic clear_from(input int from);
    for (int c = from; c < TBL; c++) begin
      e_move[c] = '0; e_load[c] = '0; e_done[c] = 0; e_err[c] = 0; e_busy[c] = 0;
      e_taps[c] = '0; dir_ev[c] = 0; dir_val[c] = '0; pos_ev[c] = 0; pos_ln[c] = 0;
      pos_val[c] = '0;
    end
  endtask

  task automatic clr_oor(input int from, input int to);
    for (int c = from; c <= to && c < TBL; c++) oor_tab[c] = '0;
  endtask

  // Whole-transaction prediction from the timing rules: k-th MOVE at
  // t0+2+(k-1)*(1+S), flag sampled S cycles later, DONE one cycle after.
  task automatic model_txn(input int t0, input int lane, input int op, input int count,
                           output int td);
    int moved, m, smp;
    bit err;
    moved = 0;
    err   = 0;
    if (lane >= NL || op == 3) begin
      td  = t0 + 1;
      err = 1;
    end else if (op == 2) begin
      e_load[t0+1] = lane_bit(lane);
      td = t0 + 2 + S;
      mdl_pos[lane] = '0;
      pos_ev[td] = 1; pos_ln[td] = lane; pos_val[td] = '0;
    end else if (count == 0) begin
      td = t0 + 1;
    end else begin
      mdl_dir[lane] = (op == 0);
      dir_ev[t0+1]  = 1;
      dir_val[t0+1] = mdl_dir;
      td = t0 + 2 + count * (1 + S);
      for (int k = 1; k <= count; k++) begin
        m   = t0 + 2 + (k - 1) * (1 + S);
        smp = m + S;
        e_move[m] = lane_bit(lane);
        if (oor_tab[smp][lane]) begin
          err = 1;
          td  = smp + 1;
          break;
        end
        mdl_pos[lane] = (op == 0) ? mdl_pos[lane] + TW'(1) : mdl_pos[lane] - TW'(1);
        pos_ev[smp+1] = 1; pos_ln[smp+1] = lane; pos_val[smp+1] = mdl_pos[lane];
        moved++;
      end
    end
    e_done[td] = 1;
    e_err[td]  = err;
    e_taps[td] = TW'(moved);
    for (int c = t0 + 1; c <= td; c++) e_busy[c] = 1;
  endtask

  always @(negedge FAB_CLK) begin
    if (!ARST_N) begin
      for (int i = 0; i < NL; i++) cur_pos[i] = '0;
      cur_dir = '0;
      check("rst_outs", 64'({MOVE, LOAD, DIRN, DONE, ERR, DONE_TAPS, REQ_READY}), 64'd0);
      check("rst_pos", 64'(RD_POS), 64'd0);
    end else if (cyc < TBL) begin
      if (dir_ev[cyc]) cur_dir = dir_val[cyc];
      if (pos_ev[cyc]) cur_pos[pos_ln[cyc]] = pos_val[cyc];
      check("ready", 64'(REQ_READY), 64'((cyc >= ready_from) && !e_busy[cyc]));
      check("move", 64'(MOVE), 64'(e_move[cyc]));
      check("load", 64'(LOAD), 64'(e_load[cyc]));
      check("done", 64'(DONE), 64'(e_done[cyc]));
      check("dir", 64'(DIRN), 64'(cur_dir));
      check("rd_pos", 64'(RD_POS), (int'(RD_LANE) < NL) ? 64'(cur_pos[int'(RD_LANE)]) : 64'd0);
      if (e_done[cyc]) begin
        check("err", 64'(ERR), 64'(e_err[cyc]));
        check("done_taps", 64'(DONE_TAPS), 64'(e_taps[cyc]));
      end
      if (MOVE != '0) obs_move_q.push_back(cyc);
      if (LOAD != '0) obs_load_q.push_back(cyc);
      if (DONE) begin
        obs_done_q.push_back(cyc);
        obs_err_q.push_back(int'(ERR));
        obs_taps_q.push_back(int'(DONE_TAPS));
      end
    end
  end

  initial begin
    OOR = '0;
    forever begin
      @(posedge FAB_CLK);
      #1;
      if (cyc < TBL) OOR = oor_tab[cyc];
    end
  end

  task automatic mid_reset();
    #2;
    ARST_N = 1'b0;
    ready_from = 1 << 30;
    #1;
    check("arst_immediate", 64'({MOVE, LOAD, DONE, REQ_READY}), 64'd0);
    clear_from(cyc);
    for (int i = 0; i < NL; i++) mdl_pos[i] = '0;
    mdl_dir = '0;
    REQ_VALID = 1'b0;
    @(posedge FAB_CLK);
    @(posedge FAB_CLK);
    #7;
    ARST_N = 1'b1;
    ready_from = cyc + 1;
    @(posedge FAB_CLK);
    #1;
    check("ready_after_rst", 64'(REQ_READY), 64'd1);
  endtask

  // Called at posedge+1 of a cycle where the controller is ready.
  task automatic run_txn(input int lane, input int op, input int count, input int abort_off,
                         output int t0, output int td);
    t0 = cyc;
    REQ_VALID = 1'b1;
    REQ_LANE  = 3'(lane);
    REQ_OP    = 2'(op);
    REQ_COUNT = TW'(count);
    RD_LANE   = 3'($urandom_range(0, 7));
    model_txn(t0, lane, op, count, td);
    @(posedge FAB_CLK);
    #1;
    while (cyc <= td) begin
      if (abort_off >= 0 && cyc == t0 + abort_off) begin
        mid_reset();
        return;
      end
      REQ_VALID = 1'($urandom_range(0, 1));
      REQ_LANE  = 3'($urandom_range(0, 7));
      REQ_OP    = 2'($urandom_range(0, 3));
      REQ_COUNT = TW'($urandom_range(0, 255));
      RD_LANE   = 3'($urandom_range(0, 7));
      @(posedge FAB_CLK);
      #1;
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      REQ_VALID = 1'b0;
      REQ_LANE  = 3'($urandom_range(0, 7));
      REQ_OP    = 2'($urandom_range(0, 3));
      RD_LANE   = 3'($urandom_range(0, 7));
      @(posedge FAB_CLK);
      #1;
    end
  endtask

  task automatic read_pos(input int lane, input string name, input int exp);
    RD_LANE = 3'(lane);
    #1;
    check(name, 64'(RD_POS), 64'(exp));
  endtask

  int t0, td, nm, nl, nd;

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    ARST_N = 1'b1;
    REQ_VALID = 1'b0; REQ_LANE = '0; REQ_OP = '0; REQ_COUNT = '0; RD_LANE = '0;
    clear_from(0);
    for (int c = 0; c < TBL; c++) begin
      oor_tab[c] = '0;
      for (int l = 0; l < NL; l++) if ($urandom_range(0, 15) == 0) oor_tab[c][l] = 1'b1;
    end
    for (int i = 0; i < NL; i++) mdl_pos[i] = '0;
    mdl_dir = '0;
    #1 ARST_N = 1'b0;
    repeat (3) @(posedge FAB_CLK);
    #7;
    ARST_N = 1'b1;
    ready_from = cyc + 1;
    @(posedge FAB_CLK);
    #1;
    check("ready_first_cycle", 64'(REQ_READY), 64'd1);

    // lane 1 up by 3
    clr_oor(cyc, cyc + 40);
    nm = obs_move_q.size(); nd = obs_done_q.size();
    run_txn(1, 0, 3, -1, t0, td);
    check("m033_model_done", 64'(td - t0), 64'd17);
    check("m033_moves", 64'(obs_move_q.size() - nm), 64'd3);
    if (obs_move_q.size() - nm == 3) begin
      check("m033_move1", 64'(obs_move_q[nm] - t0), 64'd2);
      check("m033_move2", 64'(obs_move_q[nm+1] - t0), 64'd7);
      check("m033_move3", 64'(obs_move_q[nm+2] - t0), 64'd12);
    end
    check("m033_ndone", 64'(obs_done_q.size() - nd), 64'd1);
    if (obs_done_q.size() > nd) begin
      check("m033_done_cyc", 64'(obs_done_q[nd] - t0), 64'd17);
      check("m033_err", 64'(obs_err_q[nd]), 64'd0);
      check("m033_taps", 64'(obs_taps_q[nd]), 64'd3);
    end
    check("m033_dir", 64'(DIRN[1]), 64'd1);
    read_pos(1, "m033_pos", 3);

    // lane 2 down by 5, limit raised before the third sample
    clr_oor(cyc, cyc + 60);
    for (int c = cyc + 14; c <= cyc + 30; c++) oor_tab[c][2] = 1'b1;
    nm = obs_move_q.size(); nd = obs_done_q.size();
    run_txn(2, 1, 5, -1, t0, td);
    check("m034_model_done", 64'(td - t0), 64'd17);
    check("m034_moves", 64'(obs_move_q.size() - nm), 64'd3);
    if (obs_done_q.size() > nd) begin
      check("m034_err", 64'(obs_err_q[nd]), 64'd1);
      check("m034_taps", 64'(obs_taps_q[nd]), 64'd2);
    end
    check("m034_dir", 64'(DIRN[2]), 64'd0);
    read_pos(2, "m034_pos", 254);

    // lane 0 to 7, then load
    clr_oor(cyc, cyc + 60);
    run_txn(0, 0, 7, -1, t0, td);
    read_pos(0, "m035_pre", 7);
    nl = obs_load_q.size(); nd = obs_done_q.size(); nm = obs_move_q.size();
    run_txn(0, 2, 9, -1, t0, td);
    check("m035_nload", 64'(obs_load_q.size() - nl), 64'd1);
    if (obs_load_q.size() > nl) check("m035_load_cyc", 64'(obs_load_q[nl] - t0), 64'd1);
    check("m035_nomove", 64'(obs_move_q.size() - nm), 64'd0);
    if (obs_done_q.size() > nd) begin
      check("m035_done_cyc", 64'(obs_done_q[nd] - t0), 64'd6);
      check("m035_err", 64'(obs_err_q[nd]), 64'd0);
    end
    read_pos(0, "m035_pos", 0);

    // rejected requests and a zero-count step
    nm = obs_move_q.size(); nl = obs_load_q.size(); nd = obs_done_q.size();
    run_txn(5, 0, 3, -1, t0, td);
    if (obs_done_q.size() > nd) begin
      check("m036_lane_done", 64'(obs_done_q[nd] - t0), 64'd1);
      check("m036_lane_err", 64'(obs_err_q[nd]), 64'd1);
    end
    run_txn(2, 3, 3, -1, t0, td);
    if (obs_done_q.size() > nd + 1) begin
      check("m036_op_done", 64'(obs_done_q[nd+1] - t0), 64'd1);
      check("m036_op_err", 64'(obs_err_q[nd+1]), 64'd1);
    end
    run_txn(3, 1, 0, -1, t0, td);
    if (obs_done_q.size() > nd + 2) begin
      check("m036_zero_done", 64'(obs_done_q[nd+2] - t0), 64'd1);
      check("m036_zero_err", 64'(obs_err_q[nd+2]), 64'd0);
      check("m036_zero_taps", 64'(obs_taps_q[nd+2]), 64'd0);
    end
    check("m036_nopulse", 64'((obs_move_q.size() - nm) + (obs_load_q.size() - nl)), 64'd0);

    // reset during the second settle of a count-4 step
    clr_oor(cyc, cyc + 40);
    nd = obs_done_q.size();
    run_txn(3, 0, 4, 9, t0, td);
    nm = obs_move_q.size(); nl = obs_load_q.size();
    idle_cycles(12);
    check("m037_nodone", 64'(obs_done_q.size() - nd), 64'd0);
    check("m037_nopulse", 64'((obs_move_q.size() - nm) + (obs_load_q.size() - nl)), 64'd0);
    read_pos(3, "m037_pos3", 0);
    read_pos(1, "m037_pos1", 0);

    // randomized traffic
    for (int i = 0; i < 160 && cyc < TBL - 200; i++) begin
      int r, lane, op, cnt, ab;
      r    = $urandom_range(0, 15);
      lane = $urandom_range(0, NL - 1);
      cnt  = $urandom_range(0, 6);
      op   = (r < 6) ? 0 : (r < 12) ? 1 : (r < 14) ? 2 : 3;
      if (r == 15) begin
        op   = $urandom_range(0, 2);
        lane = $urandom_range(NL, 7);
      end
      ab = (i % 50 == 25) ? $urandom_range(1, 12) : -1;
      run_txn(lane, op, cnt, ab, t0, td);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
